// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, start/done handshake; SERIAL_SUB_OVF_EN adds signed Overflow
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Overflow,
`endif
    output logic             Borrow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d, borrow_q, borrow_d, d_bit, bor_nx, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif
    always_comb begin
        d_bit    = a_q[0] ^ b_q[0] ^ bor_q;
        bor_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
        last     = cnt_q == CW'(WIDTH - 1);
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = B;
                bor_d   = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                a_msb_d = A[WIDTH-1];
                b_msb_d = B[WIDTH-1];
`endif
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {d_bit, r_q[WIDTH-1:1]};
                bor_d = bor_nx;
                cnt_d = last ? cnt_q : cnt_q + 1'b1;
                if (last) begin
                    diff_d   = r_d;
                    borrow_d = bor_nx;
                    state_d  = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH 8 and 16 against an arithmetic model
module tb_serial_subtractor;
    logic        clk = 1'b0, rst_n = 1'b0, start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  A8 = '0, B8 = '0, diff8;
    logic [15:0] A16 = '0, B16 = '0, diff16;
    logic        busy8, done8, borrow8, busy16, done16, borrow16;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf16;
`endif
    int          n_chk = 0, n_fail = 0;
    logic [15:0] prev8 = '0, prev16 = '0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8),
        .busy(busy8), .done(done8), .Diff(diff8),
`ifdef SERIAL_SUB_OVF_EN
        .Overflow(ovf8),
`endif
        .Borrow(borrow8));

    serial_subtractor #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(A16), .B(B16),
        .busy(busy16), .done(done16), .Diff(diff16),
`ifdef SERIAL_SUB_OVF_EN
        .Overflow(ovf16),
`endif
        .Borrow(borrow16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic s_done(int w);   return w == 16 ? done16 : done8;     endfunction
    function automatic logic s_busy(int w);   return w == 16 ? busy16 : busy8;     endfunction
    function automatic logic s_borrow(int w); return w == 16 ? borrow16 : borrow8; endfunction
    function automatic logic [15:0] s_diff(int w); return w == 16 ? diff16 : {8'h00, diff8}; endfunction
`ifdef SERIAL_SUB_OVF_EN
    function automatic logic s_ovf(int w);    return w == 16 ? ovf16 : ovf8;       endfunction
`endif

    task automatic op(input int w, input logic [15:0] a_in, input logic [15:0] b_in, input string tag);
        logic [15:0] m, a, b, ed, prev;
        logic        eb, eo;
        int          n;
        m    = w == 16 ? 16'hFFFF : 16'h00FF;
        a    = a_in & m;
        b    = b_in & m;
        ed   = (a - b) & m;
        eb   = a < b;
        eo   = (a[w-1] != b[w-1]) && (ed[w-1] != a[w-1]);
        prev = w == 16 ? prev16 : prev8;
        @(negedge clk);
        if (w == 16) begin A16 = a; B16 = b; start16 = 1'b1; end
        else begin A8 = a[7:0]; B8 = b[7:0]; start8 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        A8 = 8'($urandom); B8 = 8'($urandom); A16 = 16'($urandom); B16 = 16'($urandom);
        n = 1;
        chk({tag, " busy_run"}, 32'(s_busy(w)), 32'd1);
        chk({tag, " diff_held"}, 32'(s_diff(w)), 32'(prev));
        while (!s_done(w) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(w + 1));
        chk({tag, " diff"}, 32'(s_diff(w)), 32'(ed));
        chk({tag, " borrow"}, 32'(s_borrow(w)), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, " ovf"}, 32'(s_ovf(w)), 32'(eo));
`else
        if (eo) n = n;
`endif
        @(negedge clk);
        chk({tag, " done_1cyc"}, 32'(s_done(w)), 32'd0);
        chk({tag, " idle"}, 32'(s_busy(w)), 32'd0);
        if (w == 16) prev16 = ed; else prev8 = ed;
    endtask

    initial begin
        int p[$];
        int dn;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        chk("rst diff", 32'(diff8), 32'd0);
        chk("rst borrow", 32'(borrow8), 32'd0);
        chk("rst diff16", 32'(diff16), 32'd0);
        rst_n = 1'b1;
        op(8, 16'h5A, 16'h3C, "5A-3C");
        op(8, 16'h03, 16'h05, "03-05");
        op(8, 16'h00, 16'h00, "00-00");
        op(8, 16'hFF, 16'hFF, "FF-FF");
        op(8, 16'h00, 16'hFF, "00-FF");
        op(8, 16'h80, 16'h01, "80-01");
        op(8, 16'h7F, 16'h01, "7F-01");
        op(16, 16'h1234, 16'h1235, "1234-1235");
        for (int i = 0; i < 10; i++) op(8, 16'($urandom), 16'($urandom), "rnd8");
        for (int i = 0; i < 4; i++) op(16, 16'($urandom), 16'($urandom), "rnd16");
        // Held start: results must come back to back every WIDTH+2 cycles
        @(negedge clk);
        A8 = 8'h10; B8 = 8'h01; start8 = 1'b1;
        for (int t = 0; t < 36; t++) begin
            @(negedge clk);
            if (done8) begin
                p.push_back(t);
                chk("held diff", 32'(diff8), 32'h0F);
            end
        end
        start8 = 1'b0;
        chk("held count", 32'(p.size()), 32'd3);
        if (p.size() == 3) begin
            chk("held gap1", 32'(p[1] - p[0]), 32'd10);
            chk("held gap2", 32'(p[2] - p[1]), 32'd10);
        end
        repeat (12) @(negedge clk);
        prev8 = 16'h0F;
        // Reset during RUN aborts with no done pulse
        op(8, 16'h5A, 16'h3C, "pre-rst");
        @(negedge clk);
        A8 = 8'hC3; B8 = 8'h11; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort diff", 32'(diff8), 32'd0);
        chk("abort borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("abort no done", 32'(dn), 32'd0);
        prev8 = '0;
        prev16 = '0;
        op(8, 16'h03, 16'h05, "post-rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
